extend_shift_unit: RTL and testbench

Combinational extend-and-shift datapath stage with a registered 16-bit output, used by the processor to form shifted or extended immediates and shifted register/ALU values. It selects one of four sources and extends it to 16 bits. It then shifts the value logically left or right by a constant or by the 4-bit IR immediate, and registers the result on the clock.

---
 rtl/extend_shift_unit.sv | 35 +++
 tb/tb_extend_shift_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/extend_shift_unit.sv
// extend_shift_unit: selects and extends one of four sources to 16 bits, then applies a
// logical barrel shift left or right and registers the result.
module extend_shift_unit (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [3:0]  IR3_0,
  input  logic [7:0]  IR7_0,
  input  logic [15:0] Reg_A,
  input  logic [15:0] ALUOut,
  input  logic [1:0]  ShifterInput,
  input  logic        ShifterLeft,
  input  logic [1:0]  ShiftAmount,
  output logic [15:0] O
);
  logic [15:0] ext, s1, s2, s4, s8, o_q, o_d;
  logic [3:0]  n;
  // Unselected sources are excluded by the mux, so X on them never reaches O
  always_comb begin
    ext = ShifterInput == 2'b00 ? {{12{IR3_0[3]}}, IR3_0} :
          ShifterInput == 2'b01 ? {{8{IR7_0[7]}}, IR7_0} :
          ShifterInput == 2'b10 ? Reg_A : ALUOut;
    n   = ShiftAmount == 2'b00 ? 4'd1 :
          ShiftAmount == 2'b01 ? IR3_0 :
          ShiftAmount == 2'b10 ? 4'd0 : 4'd4;
    s1  = !n[0] ? ext : ShifterLeft ? {ext[14:0], 1'b0} : {1'b0, ext[15:1]};
    s2  = !n[1] ? s1  : ShifterLeft ? {s1[13:0], 2'b0}  : {2'b0, s1[15:2]};
    s4  = !n[2] ? s2  : ShifterLeft ? {s2[11:0], 4'b0}  : {4'b0, s2[15:4]};
    s8  = !n[3] ? s4  : ShifterLeft ? {s4[7:0], 8'b0}   : {8'b0, s4[15:8]};
    o_d = s8;
  end
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) o_q <= 16'h0000;
    else          o_q <= o_d;
  assign O = o_q;
endmodule

// File: tb/tb_extend_shift_unit.sv
// tb_extend_shift_unit: directed and random checks of extend_shift_unit using an expected-value queue.
module tb_extend_shift_unit;
  logic        CLK = 1'b0, Reset_n = 1'b0, ShifterLeft = 1'b0;
  logic [3:0]  IR3_0 = '0;
  logic [7:0]  IR7_0 = '0;
  logic [15:0] Reg_A = '0, ALUOut = '0, O;
  logic [1:0]  ShifterInput = '0, ShiftAmount = '0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0, checks = 0;

  extend_shift_unit dut (
    .CLK(CLK), .Reset_n(Reset_n), .IR3_0(IR3_0), .IR7_0(IR7_0), .Reg_A(Reg_A),
    .ALUOut(ALUOut), .ShifterInput(ShifterInput), .ShifterLeft(ShifterLeft),
    .ShiftAmount(ShiftAmount), .O(O)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model(input logic [1:0] sel, input logic left, input logic [1:0] amt,
                                        input logic [3:0] ir3, input logic [7:0] ir7,
                                        input logic [15:0] a, input logic [15:0] alu);
    logic [15:0] v;
    int sh;
    case (sel)
      2'd0: v = {{12{ir3[3]}}, ir3};
      2'd1: v = {{8{ir7[7]}}, ir7};
      2'd2: v = a;
      default: v = alu;
    endcase
    case (amt)
      2'd0: sh = 1;
      2'd1: sh = int'(ir3);
      2'd2: sh = 0;
      default: sh = 4;
    endcase
    return left ? v << sh : v >> sh;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] sel, input logic left, input logic [1:0] amt,
                      input logic [3:0] ir3, input logic [7:0] ir7, input logic [15:0] a,
                      input logic [15:0] alu, input logic [15:0] exp);
    ShifterInput = sel; ShifterLeft = left; ShiftAmount = amt;
    IR3_0 = ir3; IR7_0 = ir7; Reg_A = a; ALUOut = alu;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) check("queue_empty", O, 16'hxxxx);
    else check(tag_q.pop_front(), O, exp_q.pop_front());
  endtask

  initial begin
    #2;
    check("reset_initial", O, 16'h0000);
    @(negedge CLK);
    Reset_n = 1'b1;
    step("ir7_var_right", 2'b01, 1'b0, 2'b01, 4'h1, 8'h81, 16'h0, 16'h0, 16'h7FC0);
    step("ir7_var_left",  2'b01, 1'b1, 2'b01, 4'h1, 8'h81, 16'h0, 16'h0, 16'hFF02);
    step("ir7_const4",    2'b01, 1'b1, 2'b11, 4'h1, 8'h81, 16'h0, 16'h0, 16'hF810);
    step("ir7_const0",    2'b01, 1'b1, 2'b10, 4'h1, 8'h81, 16'h0, 16'h0, 16'hFF81);
    step("ir7_const1",    2'b01, 1'b1, 2'b00, 4'h1, 8'h81, 16'h0, 16'h0, 16'hFF02);
    step("ir3_left1",     2'b00, 1'b1, 2'b00, 4'h1, 8'h00, 16'h0, 16'h0, 16'h0002);
    step("ir3_sext",      2'b00, 1'b1, 2'b10, 4'h9, 8'h00, 16'h0, 16'h0, 16'hFFF9);
    step("ir3_n0_right",  2'b00, 1'b0, 2'b10, 4'h9, 8'h00, 16'h0, 16'h0, 16'hFFF9);
    step("rega_left1",    2'b10, 1'b1, 2'b00, 4'h0, 8'h00, 16'h1111, 16'h0, 16'h2222);
    step("alu_left1",     2'b11, 1'b1, 2'b00, 4'h0, 8'h00, 16'h0, 16'h0F0F, 16'h1E1E);
    step("rega_left15",   2'b10, 1'b1, 2'b01, 4'hF, 8'h00, 16'hFFFF, 16'h0, 16'h8000);
    step("rega_right15",  2'b10, 1'b0, 2'b01, 4'hF, 8'h00, 16'hFFFF, 16'h0, 16'h0001);
    step("ir7_right_nosign", 2'b01, 1'b0, 2'b11, 4'h0, 8'h80, 16'h0, 16'h0, 16'h0FF8);
    step("x_unselected",  2'b00, 1'b1, 2'b11, 4'h3, 8'hxx, 16'hxxxx, 16'hxxxx, 16'h0030);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] sel, amt;
      logic left;
      logic [3:0] ir3;
      logic [7:0] ir7;
      logic [15:0] a, alu;
      sel = 2'($urandom); amt = 2'($urandom); left = 1'($urandom);
      ir3 = 4'($urandom); ir7 = 8'($urandom); a = 16'($urandom); alu = 16'($urandom);
      step("random", sel, left, amt, ir3, ir7, a, alu, model(sel, left, amt, ir3, ir7, a, alu));
    end
    step("pre_reset",     2'b10, 1'b0, 2'b10, 4'h0, 8'h00, 16'hBEEF, 16'h0, 16'hBEEF);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", O, 16'h0000);
    @(posedge CLK);
    #1;
    check("reset_hold", O, 16'h0000);
    @(negedge CLK);
    Reset_n = 1'b1;
    #1;
    check("reset_release", O, 16'h0000);
    @(posedge CLK);
    #1;
    check("first_capture", O, 16'hBEEF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
